// File: rtl/access_mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding and default widths.
package access_mem_arbiter_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/access_mem_arbiter_if.sv
// Requester-side and RAM-side signal bundle of the arbiter.
interface access_mem_arbiter_if
    import access_mem_arbiter_pkg::*;
#(
    parameter int N  = 3,
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic [N-1:0]          req;
    logic [N-1:0]          we;
    logic [N-1:0]          lock;
    logic [N-1:0][AW-1:0]  addr;
    logic [N-1:0][DW-1:0]  wdata;
    logic [N-1:0]          gnt;
    logic [N-1:0]          rvalid;
    logic [DW-1:0]         rdata;
    logic                  lock_err;
    logic [AW-1:0]         mem_address;
    logic                  mem_wren;
    logic [DW-1:0]         mem_data;
    logic [DW-1:0]         mem_q;

    modport slave (
        input  req, we, lock, addr, wdata, mem_q,
        output gnt, rvalid, rdata, lock_err, mem_address, mem_wren, mem_data
    );
    modport master (
        output req, we, lock, addr, wdata, mem_q,
        input  gnt, rvalid, rdata, lock_err, mem_address, mem_wren, mem_data
    );
endinterface

// File: rtl/access_mem_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module rr_priority_picker #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                any = 1'b1;
                idx = IW'((int'(ptr) + k) % N);
            end
        end
        if (any) grant[idx] = 1'b1;
    end
endmodule

// File: rtl/access_mem_arbiter.sv
// Round-robin, lockable arbiter sharing one synchronous single-port RAM among N requesters.
module access_mem_arbiter
    import access_mem_arbiter_pkg::*;
#(
    parameter int N        = 3,
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int LOCK_MAX = 15
) (
    input logic                 clk,
    input logic                 rst,
    access_mem_arbiter_if.slave bus
);
    localparam int IW = idx_w(N);

    state_e          state_q, state_d;
    logic [IW-1:0]   win_q, win_d, rr_q, rr_d, own_q, own_d;
    logic [N-1:0]    win_oh_q, win_oh_d;
    logic            own_vld_q, own_vld_d, wr_q, wr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [AW-1:0]   mem_address_q, mem_address_d;
    logic            mem_wren_q, mem_wren_d;
    logic [DW-1:0]   mem_data_q, mem_data_d;

    logic [N-1:0]    elig, pick_gnt;
    logic [IW-1:0]   pick_ptr, pick_idx;
    logic            pick_any, timeout;

    // A live lock narrows eligibility to the owner; on timeout the others compete this same cycle.
    always_comb begin
        elig     = bus.req;
        pick_ptr = rr_q;
        timeout  = 1'b0;
        if (state_q == S_IDLE && own_vld_q) begin
            if (bus.req[own_q]) begin
                elig        = '0;
                elig[own_q] = 1'b1;
            end else if (cnt_q == 8'(LOCK_MAX - 1)) begin
                timeout  = 1'b1;
                pick_ptr = own_q;
            end else begin
                elig = '0;
            end
        end
    end

    rr_priority_picker #(.N(N), .IW(IW)) u_picker (
        .req   (elig),
        .ptr   (pick_ptr),
        .grant (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_d       = state_q;
        win_d         = win_q;
        win_oh_d      = win_oh_q;
        rr_d          = rr_q;
        own_d         = own_q;
        own_vld_d     = own_vld_q;
        cnt_d         = cnt_q;
        wr_d          = wr_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_wren_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (own_vld_q && !bus.req[own_q]) cnt_d = cnt_q + 8'd1;
                if (timeout) begin
                    own_vld_d = 1'b0;
                    rr_d      = own_q;
                    cnt_d     = '0;
                end
                if (pick_any) begin
                    state_d       = S_ISSUE;
                    win_d         = pick_idx;
                    win_oh_d      = pick_gnt;
                    wr_d          = bus.we[pick_idx];
                    mem_address_d = bus.addr[pick_idx];
                    mem_data_d    = bus.wdata[pick_idx];
                    mem_wren_d    = bus.we[pick_idx];
                end
            end
            S_ISSUE: begin
                rr_d      = win_q;
                own_vld_d = bus.lock[win_q];
                own_d     = win_q;
                cnt_d     = '0;
                state_d   = wr_q ? S_IDLE : S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            win_q         <= '0;
            win_oh_q      <= '0;
            rr_q          <= IW'(N - 1);
            own_q         <= '0;
            own_vld_q     <= 1'b0;
            cnt_q         <= '0;
            wr_q          <= 1'b0;
            mem_address_q <= '0;
            mem_wren_q    <= 1'b0;
            mem_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            win_oh_q      <= win_oh_d;
            rr_q          <= rr_d;
            own_q         <= own_d;
            own_vld_q     <= own_vld_d;
            cnt_q         <= cnt_d;
            wr_q          <= wr_d;
            mem_address_q <= mem_address_d;
            mem_wren_q    <= mem_wren_d;
            mem_data_q    <= mem_data_d;
        end
    end

    // RAM output is already one cycle behind the address, so read data passes straight through in RESP.
    assign bus.gnt         = (state_q == S_ISSUE) ? win_oh_q : '0;
    assign bus.rvalid      = (state_q == S_RESP)  ? win_oh_q : '0;
    assign bus.rdata       = (state_q == S_RESP)  ? bus.mem_q : '0;
    assign bus.lock_err    = timeout;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_wren    = mem_wren_q;
    assign bus.mem_data    = mem_data_q;
endmodule
